// File: rtl/timer_mmss_counter_pkg.sv
// Shared types and limits for the MM:SS countdown datapath.
//   DIGIT_W  : width of one BCD digit
//   SEC_MAX  : highest seconds value (59)
//   MIN_MAX  : highest minutes value (99)
//   bcd2_t   : two-digit BCD value {tens, units}
package timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 99;

    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] units;
    } bcd2_t;

endpackage

// File: rtl/timer_mmss_counter_bcd2_updown.sv
// Two-digit BCD up/down register with a parameterised maximum.
//   clk, rst_n     : clock, async active-low reset
//   clr_i          : synchronous clear (highest priority)
//   inc_i          : +1, wraps MAX -> 0
//   dec_i          : -1, borrows 0 -> MAX
//   value_o        : registered value
//   next_c         : combinational next value
//   zero_c         : current value is 00
//   borrow_out_c   : decrement from 00 in this cycle
module bcd2_updown
    import timer_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr_i,
    input  logic  inc_i,
    input  logic  dec_i,
    output bcd2_t value_o,
    output bcd2_t next_c,
    output logic  zero_c,
    output logic  borrow_out_c
);

    localparam bcd2_t MAX_BCD = {DIGIT_W'(MAX / 10), DIGIT_W'(MAX % 10)};
    localparam logic [DIGIT_W-1:0] NINE = DIGIT_W'(9);

    bcd2_t value_q, value_d;

    assign zero_c  = (value_q == '0);
    assign next_c  = value_d;
    assign value_o = value_q;

    // Next value: clear, then increment, then decrement.
    always_comb begin
        value_d      = value_q;
        borrow_out_c = 1'b0;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            if (value_q == MAX_BCD) begin
                value_d = '0;
            end else if (value_q.units == NINE) begin
                value_d.units = '0;
                value_d.tens  = value_q.tens + DIGIT_W'(1);
            end else begin
                value_d.units = value_q.units + DIGIT_W'(1);
            end
        end else if (dec_i) begin
            if (zero_c) begin
                value_d      = MAX_BCD;
                borrow_out_c = 1'b1;
            end else if (value_q.units == '0) begin
                value_d.units = NINE;
                value_d.tens  = value_q.tens - DIGIT_W'(1);
            end else begin
                value_d.units = value_q.units - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/timer_mmss_counter.sv
// MM:SS countdown datapath: increment edge detectors, 1 s prescaler,
// BCD seconds/minutes registers and the finish flag.
//   TICK_DIV        : clock cycles per count tick (>= 2)
//   clk, rst_n      : clock, async active-low reset
//   enable_counter  : counting allowed
//   forward         : 1 = setting mode, 0 = countdown mode
//   reset_timer     : synchronous clear of value and prescaler
//   increment_seg   : level, each rising edge adds one second (no carry)
//   increment_min   : level, each rising edge adds one minute
//   sec_/min_ digits: registered BCD outputs
//   finish          : registered, counting down at 00:00
//   tick            : combinational prescaler wrap pulse
module timer_mmss_counter
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_counter,
    input  logic               forward,
    input  logic               reset_timer,
    input  logic               increment_seg,
    input  logic               increment_min,
    output logic [DIGIT_W-1:0] sec_units,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_units,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               finish,
    output logic               tick
);

    localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic             seg_q, min_q;
    logic             armed_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             finish_q, finish_d;

    logic  count_mode_c, tick_c;
    logic  seg_edge_c, min_edge_c;
    logic  sec_inc_c, min_inc_c, sec_dec_c, min_dec_c;
    logic  sec_zero_c, min_zero_c, sec_borrow_c;
    logic  min_borrow_unused;
    bcd2_t sec_val, min_val, sec_next_c, min_next_c;

    assign count_mode_c = enable_counter & ~forward;
    assign tick_c       = count_mode_c & (pre_q == PRE_LAST);
    assign tick         = tick_c;

    // armed_q masks the first cycle after reset so a held-high input is
    // captured as a level rather than seen as a fresh edge.
    assign seg_edge_c = increment_seg & ~seg_q & armed_q;
    assign min_edge_c = increment_min & ~min_q & armed_q;

    assign sec_inc_c = ~reset_timer & forward & seg_edge_c;
    assign min_inc_c = ~reset_timer & forward & min_edge_c;

    // Countdown holds at 00:00; minutes step only on a seconds borrow.
    assign sec_dec_c = ~reset_timer & tick_c & ~(sec_zero_c & min_zero_c);
    assign min_dec_c = sec_borrow_c;

    bcd2_updown #(.MAX(SEC_MAX)) u_sec (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (reset_timer),
        .inc_i        (sec_inc_c),
        .dec_i        (sec_dec_c),
        .value_o      (sec_val),
        .next_c       (sec_next_c),
        .zero_c       (sec_zero_c),
        .borrow_out_c (sec_borrow_c)
    );

    bcd2_updown #(.MAX(MIN_MAX)) u_min (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (reset_timer),
        .inc_i        (min_inc_c),
        .dec_i        (min_dec_c),
        .value_o      (min_val),
        .next_c       (min_next_c),
        .zero_c       (min_zero_c),
        .borrow_out_c (min_borrow_unused)
    );

    // Prescaler advances only in count mode; otherwise it keeps the partial second.
    always_comb begin
        pre_d = pre_q;
        if (reset_timer) begin
            pre_d = '0;
        end else if (count_mode_c) begin
            pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
        end
    end

    assign finish_d = ~reset_timer & count_mode_c
                    & (sec_next_c == '0) & (min_next_c == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= 1'b0;
            min_q    <= 1'b0;
            armed_q  <= 1'b0;
            pre_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            seg_q    <= increment_seg;
            min_q    <= increment_min;
            armed_q  <= 1'b1;
            pre_q    <= pre_d;
            finish_q <= finish_d;
        end
    end

    assign sec_units = sec_val.units;
    assign sec_tens  = sec_val.tens;
    assign min_units = min_val.units;
    assign min_tens  = min_val.tens;
    assign finish    = finish_q;

endmodule

// File: tb/tb_timer_mmss_counter.sv
// Self-checking bench for timer_mmss_counter with TICK_DIV = 4.
module tb_timer_mmss_counter;

    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, fwd, rt, iseg, imin;
    logic [3:0] sec_units, sec_tens, min_units, min_tens;
    logic       finish, tick;
    logic [15:0] mmss;

    assign mmss = {min_tens, min_units, sec_tens, sec_units};

    always #5 clk = ~clk;

    timer_mmss_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_counter (en),
        .forward        (fwd),
        .reset_timer    (rt),
        .increment_seg  (iseg),
        .increment_min  (imin),
        .sec_units      (sec_units),
        .sec_tens       (sec_tens),
        .min_units      (min_units),
        .min_tens       (min_tens),
        .finish         (finish),
        .tick           (tick)
    );

    typedef struct {
        logic        en, fwd, rt, iseg, imin;
        logic        chk;
        logic [15:0] mmss;
        logic        fin;
        logic        tk;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[24];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic e, f, r, s, m, c,
                                input logic [15:0] mm, input logic fi, tk);
        vec_t v;
        v.en = e; v.fwd = f; v.rt = r; v.iseg = s; v.imin = m;
        v.chk = c; v.mmss = mm; v.fin = fi; v.tk = tk;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; tick is checked before the edge, digits and
    // finish after it from the scoreboard entry pushed with the stimulus.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        en = v.en; fwd = v.fwd; rt = v.rt; iseg = v.iseg; imin = v.imin;
        sb_q.push_back(v);
        #1;
        if (v.chk) cmp({tag, " tick"}, 16'(tick), 16'(v.tk));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.chk) begin
            cmp({tag, " mmss"}, mmss, e.mmss);
            cmp({tag, " finish"}, 16'(finish), 16'(e.fin));
        end
    endtask

    task automatic drv(input logic e, f, r, s, m);
        step(mk(e, f, r, s, m, 1'b0, 16'h0, 1'b0, 1'b0), "drv");
    endtask

    task automatic chk(input logic e, f, r, s, m, input logic [15:0] mm,
                       input logic fi, tk, input string tag);
        step(mk(e, f, r, s, m, 1'b1, mm, fi, tk), tag);
    endtask

    task automatic pulses(input int n, input logic s, m);
        for (int i = 0; i < n; i++) begin
            drv(1'b0, 1'b1, 1'b0, s, m);
            drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Countdown table: load 01:00, count two ticks, then load 00:02 and count to zero.
        tbl[0]  = mk(0, 1, 1, 0, 0, 1, 16'h0000, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 1, 1, 16'h0100, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 1, 16'h0100, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 16'h0100, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 1, 16'h0100, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 16'h0100, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 1, 16'h0059, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 1, 16'h0059, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 1, 16'h0059, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 1, 16'h0059, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 16'h0058, 0, 1);
        tbl[11] = mk(0, 1, 1, 0, 0, 1, 16'h0000, 0, 0);
        tbl[12] = mk(0, 1, 0, 1, 0, 1, 16'h0001, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 0, 1, 16'h0001, 0, 0);
        tbl[14] = mk(0, 1, 0, 1, 0, 1, 16'h0002, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 0, 1, 16'h0002, 0, 0);
        tbl[16] = mk(1, 0, 0, 0, 0, 1, 16'h0002, 0, 0);
        tbl[17] = mk(1, 0, 0, 0, 0, 1, 16'h0002, 0, 0);
        tbl[18] = mk(1, 0, 0, 0, 0, 1, 16'h0002, 0, 0);
        tbl[19] = mk(1, 0, 0, 0, 0, 1, 16'h0001, 0, 1);
        tbl[20] = mk(1, 0, 0, 0, 0, 1, 16'h0001, 0, 0);
        tbl[21] = mk(1, 0, 0, 0, 0, 1, 16'h0001, 0, 0);
        tbl[22] = mk(1, 0, 0, 0, 0, 1, 16'h0001, 0, 0);
        tbl[23] = mk(1, 0, 0, 0, 0, 1, 16'h0000, 1, 1);

        // Reset with every input high.
        rst_n = 1'b0; en = 1'b1; fwd = 1'b1; rt = 1'b1; iseg = 1'b1; imin = 1'b1;
        #22;
        cmp("reset mmss", mmss, 16'h0000);
        cmp("reset finish", 16'(finish), 16'h0);
        cmp("reset tick", 16'(tick), 16'h0);
        en = 1'b0; rt = 1'b0; imin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) chk(0, 1, 0, 1, 0, 16'h0000, 0, 0, "release held seg");

        // Setting mode increments.
        chk(0, 1, 0, 0, 0, 16'h0000, 0, 0, "seg low");
        for (int i = 1; i <= 3; i++) begin
            chk(0, 1, 0, 1, 0, 16'(i), 0, 0, "seg pulse");
            drv(0, 1, 0, 0, 0);
        end
        chk(0, 1, 0, 0, 1, 16'h0103, 0, 0, "min pulse 1");
        drv(0, 1, 0, 0, 0);
        chk(0, 1, 0, 0, 1, 16'h0203, 0, 0, "min pulse 2");
        drv(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) chk(0, 1, 0, 1, 0, 16'h0204, 0, 0, "seg held");
        drv(0, 1, 0, 0, 0);
        pulses(55, 1'b1, 1'b0);
        chk(0, 1, 0, 0, 0, 16'h0259, 0, 0, "seg at 59");
        pulses(1, 1'b1, 1'b0);
        chk(0, 1, 0, 0, 0, 16'h0200, 0, 0, "seg wrap no carry");
        pulses(4, 1'b1, 1'b0);
        chk(0, 1, 0, 0, 0, 16'h0204, 0, 0, "seg 60 pulses");
        pulses(97, 1'b0, 1'b1);
        chk(0, 1, 0, 0, 0, 16'h9904, 0, 0, "min at 99");
        pulses(1, 1'b0, 1'b1);
        chk(0, 1, 0, 0, 0, 16'h0004, 0, 0, "min wrap");
        chk(0, 1, 0, 1, 1, 16'h0105, 0, 0, "seg+min together");
        drv(0, 1, 0, 0, 0);
        chk(1, 1, 0, 1, 0, 16'h0106, 0, 0, "inc with enable");
        drv(1, 1, 0, 0, 0);
        chk(0, 0, 0, 1, 1, 16'h0106, 0, 0, "edges ignored fwd0");
        drv(0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0);

        // Table-driven countdown.
        for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Hold at 00:00 with finish high; ticks keep coming every 4 cycles.
        for (int i = 0; i < 20; i++)
            chk(1, 0, 0, 0, 0, 16'h0000, 1, 1'(i % 4 == 3), "hold zero");
        chk(0, 0, 0, 0, 0, 16'h0000, 0, 0, "finish drop");
        chk(1, 0, 0, 0, 0, 16'h0000, 1, 0, "start at zero");
        chk(0, 0, 0, 0, 0, 16'h0000, 0, 0, "finish drop 2");

        // Pause / resume keeps the partial second.
        chk(0, 1, 1, 0, 0, 16'h0000, 0, 0, "clear before pause");
        pulses(10, 1'b1, 1'b0);
        chk(0, 1, 0, 0, 0, 16'h0010, 0, 0, "load 00:10");
        chk(1, 0, 0, 0, 0, 16'h0010, 0, 0, "count 1");
        chk(1, 0, 0, 0, 0, 16'h0010, 0, 0, "count 2");
        for (int i = 0; i < 50; i++) chk(0, 0, 0, 0, 0, 16'h0010, 0, 0, "paused");
        chk(1, 0, 0, 0, 0, 16'h0010, 0, 0, "resume 1");
        chk(1, 0, 0, 0, 0, 16'h0009, 0, 1, "resume 2");

        // reset_timer mid-countdown with a coincident min edge.
        chk(0, 1, 1, 0, 0, 16'h0000, 0, 0, "clear before 05:30");
        pulses(5, 1'b1, 1'b1);
        pulses(25, 1'b1, 1'b0);
        chk(0, 1, 0, 0, 0, 16'h0530, 0, 0, "load 05:30");
        chk(1, 0, 0, 0, 0, 16'h0530, 0, 0, "cd 1");
        chk(1, 0, 0, 0, 0, 16'h0530, 0, 0, "cd 2");
        chk(1, 1, 1, 0, 1, 16'h0000, 0, 0, "reset_timer with min edge");
        chk(1, 1, 0, 0, 1, 16'h0000, 0, 0, "min held after clear");
        for (int i = 0; i < 3; i++) chk(1, 0, 0, 0, 0, 16'h0000, 1, 0, "prescaler cleared");
        chk(1, 0, 0, 0, 0, 16'h0000, 1, 1, "first tick after clear");

        // Asynchronous reset mid-operation.
        chk(0, 1, 0, 1, 0, 16'h0001, 0, 0, "pre async load");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async mmss", mmss, 16'h0000);
        cmp("async finish", 16'(finish), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk(0, 1, 0, 1, 0, 16'h0000, 0, 0, "async release held seg");
        drv(0, 1, 0, 0, 0);
        chk(0, 1, 0, 1, 0, 16'h0001, 0, 0, "edge after async");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_mmss_counter.md
# timer_mmss_counter

Datapath end of the countdown-timer control interface. It receives the controller's `enable_counter`, `forward`, `reset_timer`, `increment_seg` and `increment_min` outputs and holds the MM:SS value as four BCD digits. It decrements that value once per second and returns `finish` to the controller. Its digit outputs feed the VGA digit renderer.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per 1 s count tick (must be ≥ 2).
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable_counter` in 1: counting allowed.
- `forward` in 1: 1 = setting mode (increments accepted), 0 = countdown mode.
- `reset_timer` in 1: synchronous clear of value and prescaler.
- `increment_seg` in 1: level from controller; each rising edge adds one second.
- `increment_min` in 1: level from controller; each rising edge adds one minute.
- `sec_units`, `sec_tens`, `min_units`, `min_tens` out 4 each: BCD digits. Seconds range 00–59, minutes range 00–99.
- `finish` out 1: registered; high while counting down with the value at 00:00.
- `tick` out 1: one-cycle pulse when the prescaler wraps.

## Operation
- The count mode condition is `enable_counter & ~forward`.
- Edge detection: `increment_seg` and `increment_min` are each registered every cycle, in every mode, including while `reset_timer` is high. A rising edge is `in & ~in_q`. A held-high input produces exactly one increment.
- Priority per cycle:
  1. `reset_timer`
  2. increments
  3. countdown
- **`reset_timer` = 1:**
  - Digits → 00:00; prescaler → 0; `finish` → 0.
  - Edge events in that cycle are discarded.
- **Increments (`forward` = 1, `reset_timer` = 0):**
  - A seg edge sets seconds to (seconds + 1) mod 60. There is no carry into minutes.
  - A min edge sets minutes to (minutes + 1) mod 100.
  - Simultaneous seg and min edges are both applied in the same cycle.
  - Increments are accepted regardless of `enable_counter`.
- **Edges while `forward` = 0:** ignored.
- **Prescaler:**
  - Counts 0..TICK_DIV-1, advancing only in count mode.
  - When not in count mode it holds its value, so pause/resume keeps the partial second.
  - `tick` = count mode & prescaler == TICK_DIV-1; the prescaler wraps to 0 on that cycle.
- **Countdown, on `tick`:**
  - Value > 00:00: decrement by one second. Seconds 00 borrow to 59 with minutes − 1, e.g. 10:00 → 09:59.
  - Value == 00:00: hold. There is no wrap to 99:59.
- **`finish`:**
  - Next-state value is `~reset_timer & count mode & (next digit value == 00:00)`.
  - Starting a countdown at 00:00 asserts `finish` one cycle after count mode begins.
  - `finish` drops the cycle after count mode ends.

## Timing
- Reset values: all digits 0, `finish` 0, `tick` 0, prescaler 0, edge registers 0.
- Async reset mid-operation clears everything immediately. After release, a high increment input registers without generating an edge.
- Increment latency: edge visible at input in cycle n → digits updated after edge n+1.
- Countdown: the first decrement occurs TICK_DIV count-mode cycles after entry from prescaler 0.
- `finish` rises in the same cycle the digits show 00:00 (registered from next-state).
- Registered outputs: digits and `finish`. `tick` is combinational from prescaler and mode.

## Structure
- Shared package `timer_pkg`:
  - `SEC_MAX` = 59, `MIN_MAX` = 99.
  - BCD digit width 4.
  - A 2-digit BCD struct/type.
- Sub-module `bcd2_updown`, instantiated once for seconds and once for minutes:
  - Two-digit BCD register with parameter MAX.
  - Ports: inc (wrap MAX→0), dec (borrow 0→MAX with `borrow_out`), clr, zero flag.
- Top level contains the edge detectors, prescaler, priority logic and `finish` register.

## Test plan
All scenarios use TICK_DIV = 4.
1. Hold `rst_n` low with all inputs high → digits 00:00, `finish` 0, `tick` 0. Release with `increment_seg` held high → no increment.
2. `forward` = 1: apply 3 seg pulses and 2 min pulses → 02:03. Hold `increment_seg` high for 10 cycles → 02:04 only. 60 more seg pulses → 02:04, minutes unchanged. Min pulses from 99 → 00.
3. Load 01:00, then `enable_counter` = 1, `forward` = 0 → `tick` on the 4th cycle, 00:59 on the next edge. 00:58 four cycles later.
4. Load 00:02 and count → 00:00 after 8 count cycles with `finish` high in that cycle. Value stays 00:00 for a further 20 cycles with `finish` high. `enable_counter` = 0 → `finish` low next cycle.
5. Count 00:10 and drop `enable_counter` after 2 prescaler cycles for 50 cycles → digits unchanged. On resume, 00:09 appears after 2 more cycles.
6. `reset_timer` pulse mid-countdown at 05:30 with a coincident min edge and `forward` = 1 → 00:00, prescaler 0, `finish` 0, and no minute increment.
